// File: rtl/servo_array_ctrl.sv
// Multi-channel hobby-servo PWM controller with per-channel slew,
// timed dwell and a shared 1024-tick frame timebase.
// Ports:
//   clk25mhz, reset (async, active-low)
//   cmd_valid/cmd_ready, cmd_ch, cmd_mode, cmd_pos : command handshake
//   servoSignal[NUM_CH], busy[NUM_CH]              : per-channel outputs
//   frame_start                                    : pulse at frame wrap
module servo_array_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int CH_W        = 1,
  parameter int TICK_DIV    = 488,
  parameter int POS_MIN     = 51,
  parameter int POS_MAX     = 92,
  parameter int POS_CENTER  = 77,
  parameter int STEP        = 1,
  parameter int HOLD_FRAMES = 50
) (
  input  logic              clk25mhz,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [1:0]        cmd_mode,
  input  logic [9:0]        cmd_pos,
  output logic [NUM_CH-1:0] servoSignal,
  output logic [NUM_CH-1:0] busy,
  output logic              frame_start
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [9:0] CENTER = 10'(POS_CENTER);

  typedef enum logic [1:0] {
    S_OFF,
    S_SLEW,
    S_HOLD,
    S_DWELL
  } ch_st_e;

  logic [PW-1:0] presc_q, presc_d;
  logic [9:0]    frame_q, frame_d;
  logic          run_q;
  logic          tick;
  logic          cmd_fire;
  logic [9:0]    cpos;

  assign tick = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + PW'(1);
  assign frame_d = tick ? frame_q + 10'd1 : frame_q;
  assign frame_start = tick && (frame_q == 10'h3FF);

  // Blocking commands on frame_start keeps command writes and
  // frame-boundary position updates mutually exclusive.
  assign cmd_ready = run_q && !frame_start;
  assign cmd_fire = cmd_valid && cmd_ready;

  always_comb begin
    cpos = cmd_pos;
    unique case (1'b1)
      (cmd_pos < 10'(POS_MIN)): cpos = 10'(POS_MIN);
      (cmd_pos > 10'(POS_MAX)): cpos = 10'(POS_MAX);
      default: ;
    endcase
  end

  always_ff @(posedge clk25mhz or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      frame_q <= '0;
      run_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      frame_q <= frame_d;
      run_q   <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ch_st_e        st_q, st_d;
    logic [9:0]    pos_q, pos_d;
    logic [9:0]    tgt_q, tgt_d;
    logic [9:0]    gap;
    logic          timed_q, timed_d;
    logic [DW-1:0] dwl_q, dwl_d;
    logic          sig_q, busy_q;
    logic          hit;

    assign hit = cmd_fire && (cmd_ch == CH_W'(i));

    always_comb begin
      st_d    = st_q;
      pos_d   = pos_q;
      tgt_d   = tgt_q;
      timed_d = timed_q;
      dwl_d   = dwl_q;
      gap = (pos_q < tgt_q) ? tgt_q - pos_q
                            : pos_q - tgt_q;
      if (gap > 10'(STEP)) gap = 10'(STEP);
      if (hit) begin
        dwl_d = '0;
        unique case (cmd_mode)
          2'b00: begin
            tgt_d   = cpos;
            timed_d = 1'b0;
            st_d    = S_SLEW;
          end
          2'b01: begin
            tgt_d   = cpos;
            timed_d = 1'b1;
            st_d    = S_SLEW;
          end
          2'b10: begin
            tgt_d   = CENTER;
            timed_d = 1'b0;
            st_d    = S_SLEW;
          end
          default: st_d = S_OFF;
        endcase
      end else if (frame_start) begin
        unique case (st_q)
          S_SLEW: begin
            pos_d = (pos_q < tgt_q) ? pos_q + gap
                                    : pos_q - gap;
            if (pos_d == tgt_q) begin
              if (timed_q) begin
                st_d  = S_DWELL;
                dwl_d = DW'(HOLD_FRAMES);
              end else begin
                st_d = S_HOLD;
              end
            end
          end
          S_DWELL: begin
            if (dwl_q <= DW'(1)) begin
              dwl_d   = '0;
              tgt_d   = CENTER;
              timed_d = 1'b0;
              st_d    = S_SLEW;
            end else begin
              dwl_d = dwl_q - DW'(1);
            end
          end
          default: ;
        endcase
      end
    end

    // Output is built from next-state values so the registered pulse
    // lines up exactly with frame_q and reacts on the following cycle.
    always_ff @(posedge clk25mhz or negedge reset) begin
      if (!reset) begin
        st_q    <= S_OFF;
        pos_q   <= CENTER;
        tgt_q   <= CENTER;
        timed_q <= 1'b0;
        dwl_q   <= '0;
        sig_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        st_q    <= st_d;
        pos_q   <= pos_d;
        tgt_q   <= tgt_d;
        timed_q <= timed_d;
        dwl_q   <= dwl_d;
        sig_q   <= (st_d != S_OFF) && (frame_d < pos_d);
        busy_q  <= (st_d == S_SLEW) || (st_d == S_DWELL);
      end
    end

    assign servoSignal[i] = sig_q;
    assign busy[i] = busy_q;
  end

endmodule

// File: tb/tb_servo_array_ctrl.sv
// Bench for servo_array_ctrl: two instances (STEP 1 and STEP 26)
// share one command bus; pulse widths are measured per frame.
module tb_servo_array_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v = 1'b0;
  logic [1:0] ch = '0;
  logic [1:0] mode = '0;
  logic [9:0] pos = '0;
  logic       rdy_a, rdy_b, fs_a, fs_b;
  logic [1:0] sig_a, sig_b, busy_a, busy_b;
  logic [3:0] sig4;

  always #5 clk = ~clk;

  servo_array_ctrl #(
    .NUM_CH(2), .CH_W(2), .TICK_DIV(2),
    .POS_MIN(51), .POS_MAX(92), .POS_CENTER(77),
    .STEP(1), .HOLD_FRAMES(3)
  ) dut_a (
    .clk25mhz(clk), .reset(rst_n),
    .cmd_valid(v), .cmd_ready(rdy_a),
    .cmd_ch(ch), .cmd_mode(mode), .cmd_pos(pos),
    .servoSignal(sig_a), .busy(busy_a),
    .frame_start(fs_a)
  );

  servo_array_ctrl #(
    .NUM_CH(2), .CH_W(2), .TICK_DIV(2),
    .POS_MIN(51), .POS_MAX(92), .POS_CENTER(77),
    .STEP(26), .HOLD_FRAMES(3)
  ) dut_b (
    .clk25mhz(clk), .reset(rst_n),
    .cmd_valid(v), .cmd_ready(rdy_b),
    .cmd_ch(ch), .cmd_mode(mode), .cmd_pos(pos),
    .servoSignal(sig_b), .busy(busy_b),
    .frame_start(fs_b)
  );

  // index 0 A0, 1 A1, 2 B0, 3 B1
  assign sig4 = {sig_b, sig_a};

  int cnt[4];
  int wid[4];
  int cyc;
  int per;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) cnt[k] <= 0;
      cyc <= 0;
    end else if (fs_a) begin
      for (int k = 0; k < 4; k++) begin
        wid[k] <= cnt[k] + int'(sig4[k]);
        cnt[k] <= 0;
      end
      per <= cyc + 1;
      cyc <= 0;
    end else begin
      for (int k = 0; k < 4; k++)
        cnt[k] <= cnt[k] + int'(sig4[k]);
      cyc <= cyc + 1;
    end
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_fs();
    int n = 0;
    @(negedge clk);
    while (!fs_a && n < 2100) begin
      @(negedge clk);
      n++;
    end
    if (!fs_a) begin
      checks++;
      errs++;
      $display("FAIL fs_timeout: got no frame_start in %0d cycles", n);
    end
    #1;
  endtask

  task automatic send(input logic [1:0] c, input logic [1:0] m,
                      input logic [9:0] p);
    ch = c;
    mode = m;
    pos = p;
    v = 1'b1;
    @(negedge clk);
    v = 1'b0;
  endtask

  typedef struct {
    bit         cmd;
    logic [1:0] ch;
    logic [1:0] mode;
    logic [9:0] pos;
    logic [3:0] bc;
    int         w0;
    int         w1;
    int         w2;
    int         w3;
    logic [3:0] bf;
  } vec_t;

  vec_t vt[19];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b0, 2'd0, 2'd0, 10'd0,    4'b0000, 0,   0,   0,   0,   4'b0000};
    vt[1]  = '{1'b1, 2'd0, 2'd2, 10'd0,    4'b0101, 0,   0,   0,   0,   4'b0000};
    vt[2]  = '{1'b1, 2'd0, 2'd0, 10'd92,   4'b0101, 154, 0,   154, 0,   4'b0001};
    vt[3]  = '{1'b1, 2'd1, 2'd1, 10'd51,   4'b1011, 156, 0,   184, 0,   4'b1011};
    vt[4]  = '{1'b0, 2'd0, 2'd0, 10'd0,    4'b0000, 158, 152, 184, 102, 4'b1011};
    vt[5]  = '{1'b1, 2'd3, 2'd0, 10'd60,   4'b1011, 160, 150, 184, 102, 4'b1011};
    vt[6]  = '{1'b0, 2'd0, 2'd0, 10'd0,    4'b0000, 162, 148, 184, 102, 4'b1011};
    vt[7]  = '{1'b0, 2'd0, 2'd0, 10'd0,    4'b0000, 164, 146, 184, 102, 4'b0011};
    vt[8]  = '{1'b0, 2'd0, 2'd0, 10'd0,    4'b0000, 166, 144, 184, 154, 4'b0011};
    vt[9]  = '{1'b1, 2'd1, 2'd0, 10'd1000, 4'b1011, 168, 142, 184, 154, 4'b0011};
    vt[10] = '{1'b1, 2'd1, 2'd0, 10'd0,    4'b1011, 170, 144, 184, 184, 4'b1011};
    vt[11] = '{1'b0, 2'd0, 2'd0, 10'd0,    4'b0000, 172, 142, 184, 132, 4'b0011};
    vt[12] = '{1'b1, 2'd1, 2'd3, 10'd0,    4'b0001, 174, 140, 184, 102, 4'b0001};
    vt[13] = '{1'b0, 2'd0, 2'd0, 10'd0,    4'b0000, 176, 0,   184, 0,   4'b0001};
    vt[14] = '{1'b0, 2'd0, 2'd0, 10'd0,    4'b0000, 178, 0,   184, 0,   4'b0001};
    vt[15] = '{1'b0, 2'd0, 2'd0, 10'd0,    4'b0000, 180, 0,   184, 0,   4'b0001};
    vt[16] = '{1'b0, 2'd0, 2'd0, 10'd0,    4'b0000, 182, 0,   184, 0,   4'b0000};
    vt[17] = '{1'b0, 2'd0, 2'd0, 10'd0,    4'b0000, 184, 0,   184, 0,   4'b0000};
    vt[18] = '{1'b0, 2'd0, 2'd0, 10'd0,    4'b0000, 184, 0,   184, 0,   4'b0000};

    repeat (3) @(negedge clk);
    chk("rst_sig", int'({sig_b, sig_a}), 0);
    chk("rst_busy", int'({busy_b, busy_a}), 0);
    chk("rst_ready", int'({rdy_b, rdy_a}), 0);
    chk("rst_fs", int'({fs_b, fs_a}), 0);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      if (vt[i].cmd) begin
        send(vt[i].ch, vt[i].mode, vt[i].pos);
        chk($sformatf("v%0d busy_cmd", i),
            int'({busy_b, busy_a}), int'(vt[i].bc));
      end
      wait_fs();
      chk($sformatf("v%0d w_a0", i), wid[0], vt[i].w0);
      chk($sformatf("v%0d w_a1", i), wid[1], vt[i].w1);
      chk($sformatf("v%0d w_b0", i), wid[2], vt[i].w2);
      chk($sformatf("v%0d w_b1", i), wid[3], vt[i].w3);
      @(negedge clk);
      chk($sformatf("v%0d busy_fs", i),
          int'({busy_b, busy_a}), int'(vt[i].bf));
      repeat (300) @(negedge clk);
    end

    // command held valid across frame_start; ch1 resumes from pos 51/70
    wait_fs();
    chk("h1 w_a0", wid[0], 184);
    chk("h1 period", per, 2048);
    chk("h1 ready_fs", int'(rdy_a), 0);
    ch = 2'd1;
    mode = 2'd2;
    pos = 10'd0;
    v = 1'b1;
    @(posedge clk);
    #1;
    chk("h1 busy_b1_early", int'(busy_b[1]), 0);
    chk("h1 ready_after", int'(rdy_a), 1);
    @(posedge clk);
    #1;
    chk("h1 busy_b1_xfer", int'(busy_b[1]), 1);
    chk("h1 busy_a1_xfer", int'(busy_a[1]), 1);
    v = 1'b0;
    wait_fs();
    chk("h1 w_b1_resume", wid[3], 101);
    chk("h1 w_a1_resume", wid[1], 139);
    @(negedge clk);
    chk("h1 busy_b1_hold", int'(busy_b[1]), 0);

    // off during dwell, then resume from the retained position
    repeat (300) @(negedge clk);
    send(2'd1, 2'd1, 10'd51);
    chk("h2 busy_b1_timed", int'(busy_b[1]), 1);
    wait_fs();
    @(negedge clk);
    repeat (20) @(negedge clk);
    chk("h2 sig_b1_dwell", int'(sig_b[1]), 1);
    ch = 2'd1;
    mode = 2'd3;
    v = 1'b1;
    @(posedge clk);
    #1;
    chk("h2 sig_b1_off", int'(sig_b[1]), 0);
    chk("h2 busy_b1_off", int'(busy_b[1]), 0);
    @(negedge clk);
    v = 1'b0;
    repeat (280) @(negedge clk);
    send(2'd1, 2'd0, 10'd92);
    chk("h2 busy_b1_hold_cmd", int'(busy_b[1]), 1);
    wait_fs();
    @(negedge clk);
    chk("h2 busy_b1_slewing", int'(busy_b[1]), 1);
    wait_fs();
    chk("h2 w_b1_from_51", wid[3], 154);
    @(negedge clk);
    chk("h2 busy_b1_done", int'(busy_b[1]), 0);

    // reset in the middle of a pulse
    repeat (20) @(negedge clk);
    chk("h3 sig_b1_pre", int'(sig_b[1]), 1);
    rst_n = 1'b0;
    #1;
    chk("h3 rst_sig", int'({sig_b, sig_a}), 0);
    chk("h3 rst_busy", int'({busy_b, busy_a}), 0);
    chk("h3 rst_ready", int'(rdy_a), 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    wait_fs();
    chk("h3 w_sum", wid[0] + wid[1] + wid[2] + wid[3], 0);
    @(negedge clk);
    chk("h3 busy", int'({busy_b, busy_a}), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
